serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor: diff = a - b - bin. Processes one bit per clock, LSB first, through a single full-subtractor cell.
- Companion to the ripple-carry adder in the arithmetic library. It is the inverse operation and trades latency for area.
- Multi-cycle start/ready/done handshake, for use in area-constrained datapaths and ALU sequencers.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor.
//   - state_t : 2-bit FSM state type, with IDLE / RUN / DONE constants.
//   - cnt_width() : bit-counter width for a given operand width.
// ----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Counter must index bits 0..w-1. Keep at least one bit so the
    // counter vector is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
//   Single-bit full subtractor cell: computes a - b - bin.
//   Ports:
//     a, b  : operand bits
//     bin   : borrow in
//     d     : difference bit
//     bout  : borrow out (set when a < b + bin)
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b - bin (modulo 2^WIDTH).
//   One bit per clock, LSB first, through a single full_subtractor cell.
//   A start/ready/done handshake frames each operation; an operation takes
//   WIDTH RUN cycles plus one DONE cycle, and one op is accepted every
//   WIDTH+2 cycles when start is held high.
//
//   Ports:
//     clk    : rising-edge clock
//     rst    : synchronous active-high reset
//     start  : request, accepted only while ready=1
//     a, b   : minuend / subtrahend, sampled on the accept edge
//     bin    : borrow in, sampled on the accept edge
//     ready  : high in IDLE
//     busy   : high in RUN
//     done   : one-cycle pulse, result outputs valid
//     diff   : difference, held until the next completed operation
//     bout   : unsigned borrow out (a < b + bin)
//     ovf    : two's-complement overflow
//
//   Optional (macro SERIAL_SUBTRACTOR_CMP_EN):
//     a_lt_b : registered copy of bout
//     zero   : registered (diff == 0)
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
`ifdef SERIAL_SUBTRACTOR_CMP_EN
    ,
    output logic             a_lt_b,
    output logic             zero
`endif
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             borrow_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] res_nxt;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d),
        .bout (borrow_nxt)
    );

    assign last_bit = (cnt == LAST);
    // Result fills from the top so that after WIDTH shifts bit 0 sits at LSB.
    assign res_nxt  = {d, res[WIDTH-1:1]};

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, matching real flip-flop behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_CMP_EN
            a_lt_b <= 1'b0;
            zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end

                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res    <= res_nxt;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // Publish on the MSB edge so outputs are valid for the
                        // whole DONE cycle. Overflow is the borrow disagreement
                        // across the sign bit.
                        state <= DONE;
                        diff  <= res_nxt;
                        bout  <= borrow_nxt;
                        ovf   <= borrow ^ borrow_nxt;
`ifdef SERIAL_SUBTRACTOR_CMP_EN
                        a_lt_b <= borrow_nxt;
                        zero   <= (res_nxt == '0);
`else
                        // Compare flags not built in this configuration.
`endif
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor (WIDTH=4). Expected results are
//   computed with plain integer arithmetic and queued when an operation is
//   issued; a monitor pops and compares whenever done is high.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
`ifdef SERIAL_SUBTRACTOR_CMP_EN
    logic         a_lt_b;
    logic         zero;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .bout   (bout),
        .ovf    (ovf)
`ifdef SERIAL_SUBTRACTOR_CMP_EN
        ,
        .a_lt_b (a_lt_b),
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    bit   ready_chk = 0;
    bit   hold_win  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer subtraction on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin, input int acc);
        exp_t r;
        int ua = int'(ma);
        int ub = int'(mb);
        int sa = ma[W-1] ? ua - (1 << W) : ua;
        int sb_ = mb[W-1] ? ub - (1 << W) : ub;
        int sd = sa - sb_ - int'(mbin);
        int ud = ua - ub - int'(mbin);
        r.diff = W'(ud);
        r.bout = (ua < ub + int'(mbin));
        r.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        r.zero = (r.diff == '0);
        r.acc  = acc;
        return r;
    endfunction

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (ready_chk) begin
            check("ready_after_done", ready, 1);
            ready_chk = 0;
        end
        if (hold_win)
            check("ready_busy_excl", ready & busy, 0);
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got diff=%0h with no pending op (t=%0t)", diff, $time);
            end else begin
                e = sb.pop_front();
                check("diff",    diff, e.diff);
                check("bout",    bout, e.bout);
                check("ovf",     ovf,  e.ovf);
                check("latency", cyc - e.acc, W);
`ifdef SERIAL_SUBTRACTOR_CMP_EN
                check("a_lt_b",  a_lt_b, e.bout);
                check("zero",    zero,   e.zero);
`endif
                ready_chk = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 50 cycles");
            return;
        end
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        sb.push_back(model(ta, tb_v, tbin, cyc + 1));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(ready && sb.size() == 0) && n < 100) begin
            tick();
            n++;
        end
        if (!(ready && sb.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got pending=%0d ready=%0b expected 0 and 1", sb.size(), ready);
        end
    endtask

    initial begin
        int c0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", ready, 1);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_diff",  diff,  0);
        check("rst_bout",  bout,  0);
        check("rst_ovf",   ovf,   0);
`ifdef SERIAL_SUBTRACTOR_CMP_EN
        check("rst_a_lt_b", a_lt_b, 0);
        check("rst_zero",   zero,   0);
`endif

        // Directed cases
        do_op(4'd7, 4'd3, 1'b0);
        do_op(4'd3, 4'd5, 1'b0);
        do_op(4'd8, 4'd1, 1'b0);
        do_op(4'd0, 4'd0, 1'b1);
        do_op(4'd5, 4'd5, 1'b0);

        // start during RUN is ignored; new operands have no effect
        do_op(4'd9, 4'd2, 1'b0);
        tick();
        a     = 4'd1;
        b     = 4'd1;
        bin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();

        // Reset in RUN cycle 2: no done, outputs back to reset values
        a     = 4'd4;
        b     = 4'd1;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_busy",  busy,  0);
        check("midrst_done",  done,  0);
        check("midrst_diff",  diff,  0);
        check("midrst_bout",  bout,  0);
        check("midrst_ovf",   ovf,   0);
        repeat (W + 3) tick();

        // start held high: one accept every W+2 cycles
        wait_idle();
        hold_win = 1;
        a     = 4'd6;
        b     = 4'd1;
        bin   = 1'b0;
        start = 1'b1;
        c0    = cyc;
        for (int k = 0; k < 4; k++)
            sb.push_back(model(4'd6, 4'd1, 1'b0, c0 + 1 + k * (W + 2)));
        repeat (20) tick();
        start = 1'b0;
        wait_idle();
        hold_win = 0;

        // Random operations
        for (int i = 0; i < 40; i++)
            do_op(W'($urandom_range(0, (1 << W) - 1)),
                  W'($urandom_range(0, (1 << W) - 1)),
                  1'($urandom_range(0, 1)));
        wait_idle();
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
